// File: rtl/md_issue_ctrl.sv
// E-stage issue/stall controller in front of the multiply/divide unit.
// Optional MD_PERF_CNT_EN adds stall-cycle and mul/div-issue counters.
module md_issue_ctrl #(
    parameter int OP_W    = 4,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] e_md_op,
    input  logic            e_valid,
    input  logic            e_hold,
    input  logic            req,
    input  logic            d_md_use,
    input  logic            md_busy,
    output logic [OP_W-1:0] md_start,
    output logic            stall_md,
    output logic            proto_err,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_issue
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t           state_reg, state_next;
    logic             issued_reg;
    logic [CNT_W-1:0] shadow_reg, shadow_next;
    logic             proto_err_reg;
    logic             err_set;
    logic             op_ok, ld, is_mul;

    assign op_ok = (e_md_op >= OP_W'(1)) && (e_md_op <= OP_W'(8));

    always_comb begin
        md_start = '0;
        if (!reset && e_valid && !req && !issued_reg && op_ok)
            md_start = e_md_op;
    end

    assign ld     = (md_start >= OP_W'(1)) && (md_start <= OP_W'(4));
    assign is_mul = (md_start == OP_W'(1)) || (md_start == OP_W'(2));

    always_comb begin
        shadow_next = shadow_reg;
        if (ld)
            shadow_next = is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
        else if (shadow_reg != '0)
            shadow_next = shadow_reg - CNT_W'(1);
    end

    // Shadow counter and md_busy must agree; any disagreement is latched as proto_err.
    always_comb begin
        state_next = state_reg;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ld) state_next = LAUNCH;
            end
            LAUNCH: begin
                if (ld) begin
                    state_next = LAUNCH;
                end else if (md_busy) begin
                    state_next = RUN;
                end else begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (ld) begin
                    state_next = LAUNCH;
                end else if (md_busy) begin
                    if (shadow_reg == '0) err_set = 1'b1;
                end else if (shadow_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            issued_reg    <= 1'b0;
            shadow_reg    <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shadow_reg    <= shadow_next;
            proto_err_reg <= proto_err_reg | err_set;
            // One start per E-stage instruction: remember the issue only while E is held.
            if (req || !e_hold)
                issued_reg <= 1'b0;
            else if (md_start != '0)
                issued_reg <= 1'b1;
        end
    end

    assign stall_md  = d_md_use & (ld | md_busy | (shadow_reg != '0));
    assign proto_err = proto_err_reg;

`ifdef MD_PERF_CNT_EN
    logic [31:0] perf_stall_reg, perf_issue_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_reg <= '0;
            perf_issue_reg <= '0;
        end else begin
            if (stall_md) perf_stall_reg <= perf_stall_reg + 32'd1;
            if (ld)       perf_issue_reg <= perf_issue_reg + 32'd1;
        end
    end

    assign perf_stall = perf_stall_reg;
    assign perf_issue = perf_issue_reg;
`else
    assign perf_stall = 32'd0;
    assign perf_issue = 32'd0;
`endif

endmodule
